// File: rtl/vram_trace_writer_if.sv
// Sample stream in, VRAM write port out, for the trace writer.
interface vram_trace_writer_if;
  logic signed [9:0] sampleData;
  logic              sampleValid;
  logic              sampleReady;
  logic [9:0]        vramWriteAddr;
  logic signed [9:0] vramInData;
  logic              vramWrEn;
  logic              frameDone;

  // Writer side: consumes samples, drives the RAM write port.
  modport master (
    input  sampleData, sampleValid,
    output sampleReady, vramWriteAddr, vramInData, vramWrEn, frameDone
  );

  // Environment side: sample source and RAM.
  modport slave (
    output sampleData, sampleValid,
    input  sampleReady, vramWriteAddr, vramInData, vramWrEn, frameDone
  );
endinterface

// File: rtl/vram_trace_writer.sv
// Writes one captured trace per frame into the VGA column buffer RAM.
// A capture starts on a vSync falling edge, optionally waits for a rising
// level crossing, then writes COLUMNS clamped Y values at addresses 0..N-1.
module vram_trace_writer #(
  parameter int unsigned COLUMNS      = 1024,
  parameter int          CLAMP_MIN    = 16,
  parameter int          CLAMP_MAX    = 752,
  parameter int unsigned TRIG_TIMEOUT = 2048
) (
  input  logic                inClock,
  input  logic                resetN,
  input  logic                vSync,
  input  logic [1:0]          runMode,
  input  logic                trigEnable,
  input  logic signed [9:0]   trigLevel,
  output logic                busy,
  vram_trace_writer_if.master bus
);
  localparam int unsigned COL_W = 10;
  localparam int unsigned TMO_W = $clog2(TRIG_TIMEOUT + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_TRIG,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic signed [9:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [9:0]        addr_q, addr_d;
  logic signed [9:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              vs_meta_q, vs_sync_q, vs_prev_q;

  logic              vs_edge_c;
  logic              accept_c;
  logic              stop_c;
  logic              trig_hit_c;
  logic signed [9:0] clamped_c;

  // vSync is asynchronous to inClock: two-flop synchronizer plus edge history.
  always_ff @(posedge inClock or negedge resetN) begin
    if (!resetN) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_meta_q <= vSync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign vs_edge_c  = vs_prev_q & ~vs_sync_q;
  assign accept_c   = bus.sampleValid & ready_q;
  assign stop_c     = (runMode == 2'b00) || (runMode == 2'b11);
  assign trig_hit_c = (prev_valid_q && (prev_q < trigLevel) && (bus.sampleData >= trigLevel))
                   || (tmo_q == TMO_W'(TRIG_TIMEOUT));

  // Limit the sample to the visible Y range; limits compare as plain integers.
  always_comb begin
    clamped_c = bus.sampleData;
    if (int'(bus.sampleData) < CLAMP_MIN) begin
      clamped_c = 10'(CLAMP_MIN);
    end else if (int'(bus.sampleData) > CLAMP_MAX) begin
      clamped_c = 10'(CLAMP_MAX);
    end
  end

  // Next-state and next-output logic; stop mode overrides every state.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    tmo_d        = tmo_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    done_d       = 1'b0;

    if (stop_c) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          col_d        = '0;
          prev_valid_d = 1'b0;
          tmo_d        = '0;
          if (vs_edge_c) begin
            state_d = trigEnable ? S_TRIG : S_WRITE;
          end
        end
        S_TRIG: begin
          if (accept_c) begin
            if (trig_hit_c) begin
              wren_d  = 1'b1;
              addr_d  = '0;
              data_d  = clamped_c;
              col_d   = COL_W'(1);
              state_d = S_WRITE;
            end else begin
              prev_d       = bus.sampleData;
              prev_valid_d = 1'b1;
              tmo_d        = tmo_q + TMO_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (accept_c) begin
            wren_d = 1'b1;
            addr_d = col_q;
            data_d = clamped_c;
            if (col_q == LAST_COL) begin
              done_d  = 1'b1;
              state_d = (runMode == 2'b01) ? S_ARMED : S_DONE;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d == S_TRIG) || (state_d == S_WRITE);
    busy_d  = ready_d || (state_d == S_ARMED);
  end

  // State and registered outputs.
  always_ff @(posedge inClock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      tmo_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      tmo_q        <= tmo_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sampleReady   = ready_q;
  assign bus.vramWriteAddr = addr_q;
  assign bus.vramInData    = data_q;
  assign bus.vramWrEn      = wren_q;
  assign bus.frameDone     = done_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_vram_trace_writer.sv
// Directed bench for vram_trace_writer.
module tb_vram_trace_writer;
  localparam int CMAX = 400;

  logic              inClock = 1'b0;
  logic              resetN = 1'b0;
  logic              vSync = 1'b1;
  logic [1:0]        runMode = 2'b00;
  logic              trigEnable = 1'b0;
  logic signed [9:0] trigLevel = 10'sd0;
  logic              busy;
  int                checks = 0;
  int                errors = 0;

  vram_trace_writer_if bus();

  vram_trace_writer #(.CLAMP_MAX(CMAX)) dut (
    .inClock(inClock),
    .resetN(resetN),
    .vSync(vSync),
    .runMode(runMode),
    .trigEnable(trigEnable),
    .trigLevel(trigLevel),
    .busy(busy),
    .bus(bus)
  );

  always #5 inClock = ~inClock;

  task automatic vs_pulse();
    @(negedge inClock);
    vSync = 1'b0;
    repeat (4) @(negedge inClock);
    vSync = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.sampleReady !== 1'b1 && n < 10) begin
      @(negedge inClock);
      n++;
    end
    checks++;
    if (bus.sampleReady !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: got ready=%b expected 1", tag, bus.sampleReady);
    end
  endtask

  task automatic abort_capture();
    @(negedge inClock);
    runMode = 2'b00;
    bus.sampleValid = 1'b0;
    repeat (2) @(negedge inClock);
  endtask

  task automatic test_reset();
    bus.sampleValid = 1'b0;
    bus.sampleData  = 10'sd0;
    #12;
    checks++;
    if (bus.vramWrEn !== 1'b0 || bus.vramWriteAddr !== 10'd0 || bus.vramInData !== 10'sd0 ||
        bus.frameDone !== 1'b0 || busy !== 1'b0 || bus.sampleReady !== 1'b0) begin
      errors++;
      $display("FAIL reset: got we=%b addr=%0d data=%0d fd=%b busy=%b rdy=%b expected all 0",
               bus.vramWrEn, bus.vramWriteAddr, bus.vramInData, bus.frameDone, busy, bus.sampleReady);
    end
    @(negedge inClock);
    resetN = 1'b1;
  endtask

  task automatic test_continuous();
    runMode = 2'b01;
    trigEnable = 1'b0;
    repeat (2) @(negedge inClock);
    checks++;
    if (busy !== 1'b1 || bus.sampleReady !== 1'b0) begin
      errors++;
      $display("FAIL cont_armed: got busy=%b rdy=%b expected busy=1 rdy=0", busy, bus.sampleReady);
    end
    vs_pulse();
    wait_ready("cont");
    bus.sampleValid = 1'b1;
    bus.sampleData  = 10'sd100;
    for (int i = 0; i < 1024; i++) begin
      @(negedge inClock);
      if (i == 1023) bus.sampleValid = 1'b0;
      checks++;
      if (bus.vramWrEn !== 1'b1 || bus.vramWriteAddr !== 10'(i) || bus.vramInData !== 10'sd100 ||
          bus.frameDone !== (i == 1023) || busy !== 1'b1) begin
        errors++;
        $display("FAIL cont_write: got we=%b addr=%0d data=%0d fd=%b busy=%b expected 1/%0d/100/%b/1",
                 bus.vramWrEn, bus.vramWriteAddr, bus.vramInData, bus.frameDone, busy, i, i == 1023);
      end
    end
    @(negedge inClock);
    checks++;
    if (bus.vramWrEn !== 1'b0 || bus.frameDone !== 1'b0 || busy !== 1'b1 || bus.sampleReady !== 1'b0) begin
      errors++;
      $display("FAIL cont_rearm: got we=%b fd=%b busy=%b rdy=%b expected 0/0/1/0",
               bus.vramWrEn, bus.frameDone, busy, bus.sampleReady);
    end
  endtask

  task automatic test_clamp();
    int vin [7]  = '{-5, 10, 16, 400, 401, 511, -512};
    int vexp [7] = '{16, 16, 16, 400, 400, 400, 16};
    vs_pulse();
    wait_ready("clamp");
    bus.sampleValid = 1'b1;
    bus.sampleData  = 10'(vin[0]);
    for (int k = 0; k < 7; k++) begin
      @(negedge inClock);
      if (k < 6) bus.sampleData = 10'(vin[k + 1]);
      else bus.sampleValid = 1'b0;
      checks++;
      if (bus.vramWrEn !== 1'b1 || bus.vramWriteAddr !== 10'(k) || bus.vramInData !== 10'(vexp[k])) begin
        errors++;
        $display("FAIL clamp: in=%0d got we=%b addr=%0d data=%0d expected 1/%0d/%0d",
                 vin[k], bus.vramWrEn, bus.vramWriteAddr, bus.vramInData, k, vexp[k]);
      end
    end
    abort_capture();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_stop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_trigger();
    int ramp [5]  = '{290, 295, 299, 300, 305};
    int ewe [5]   = '{0, 0, 0, 1, 1};
    int eaddr [5] = '{0, 0, 0, 0, 1};
    runMode = 2'b01;
    trigEnable = 1'b1;
    trigLevel = 10'sd300;
    repeat (2) @(negedge inClock);
    vs_pulse();
    wait_ready("trig");
    bus.sampleValid = 1'b1;
    bus.sampleData  = 10'(ramp[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge inClock);
      if (k < 4) bus.sampleData = 10'(ramp[k + 1]);
      else bus.sampleValid = 1'b0;
      checks++;
      if (bus.vramWrEn !== ewe[k][0] ||
          (ewe[k] == 1 && (bus.vramWriteAddr !== 10'(eaddr[k]) || bus.vramInData !== 10'(ramp[k])))) begin
        errors++;
        $display("FAIL trigger: in=%0d got we=%b addr=%0d data=%0d expected we=%0d addr=%0d data=%0d",
                 ramp[k], bus.vramWrEn, bus.vramWriteAddr, bus.vramInData, ewe[k], eaddr[k], ramp[k]);
      end
    end
    abort_capture();
  endtask

  task automatic test_timeout();
    int wr = 0;
    runMode = 2'b01;
    trigEnable = 1'b1;
    trigLevel = 10'sd300;
    repeat (2) @(negedge inClock);
    vs_pulse();
    wait_ready("tmo");
    bus.sampleValid = 1'b1;
    bus.sampleData  = 10'sd0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge inClock);
      if (bus.vramWrEn === 1'b1) wr++;
    end
    checks++;
    if (wr != 0) begin
      errors++;
      $display("FAIL tmo_discard: got %0d writes expected 0", wr);
    end
    @(negedge inClock);
    bus.sampleValid = 1'b0;
    checks++;
    if (bus.vramWrEn !== 1'b1 || bus.vramWriteAddr !== 10'd0 || bus.vramInData !== 10'sd16) begin
      errors++;
      $display("FAIL tmo_force: got we=%b addr=%0d data=%0d expected 1/0/16",
               bus.vramWrEn, bus.vramWriteAddr, bus.vramInData);
    end
    abort_capture();
  endtask

  task automatic test_single();
    int bad = 0;
    int fd = 0;
    int wr = 0;
    runMode = 2'b10;
    trigEnable = 1'b0;
    repeat (2) @(negedge inClock);
    vs_pulse();
    wait_ready("single");
    bus.sampleValid = 1'b1;
    bus.sampleData  = 10'sd200;
    for (int i = 0; i < 1024; i++) begin
      @(negedge inClock);
      if (bus.vramWrEn !== 1'b1 || bus.vramWriteAddr !== 10'(i) || bus.vramInData !== 10'sd200) bad++;
      if (bus.frameDone === 1'b1) fd++;
    end
    checks++;
    if (bad != 0 || fd != 1 || bus.frameDone !== 1'b1) begin
      errors++;
      $display("FAIL single_capture: got bad=%0d fd_count=%0d last_fd=%b expected 0/1/1",
               bad, fd, bus.frameDone);
    end
    @(negedge inClock);
    checks++;
    if (bus.sampleReady !== 1'b0 || busy !== 1'b0 || bus.vramWrEn !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got rdy=%b busy=%b we=%b expected 0/0/0",
               bus.sampleReady, busy, bus.vramWrEn);
    end
    for (int r = 0; r < 2; r++) begin
      vs_pulse();
      repeat (6) begin
        @(negedge inClock);
        if (bus.vramWrEn === 1'b1 || bus.sampleReady === 1'b1) wr++;
      end
    end
    checks++;
    if (wr != 0) begin
      errors++;
      $display("FAIL single_hold: got %0d active cycles expected 0", wr);
    end
    bus.sampleValid = 1'b0;
    runMode = 2'b00;
    repeat (2) @(negedge inClock);
    runMode = 2'b10;
    repeat (2) @(negedge inClock);
    checks++;
    if (busy !== 1'b1 || bus.sampleReady !== 1'b0) begin
      errors++;
      $display("FAIL single_rearm: got busy=%b rdy=%b expected 1/0", busy, bus.sampleReady);
    end
    vs_pulse();
    wait_ready("single2");
    bus.sampleValid = 1'b1;
    bus.sampleData  = 10'sd250;
    @(negedge inClock);
    bus.sampleValid = 1'b0;
    checks++;
    if (bus.vramWrEn !== 1'b1 || bus.vramWriteAddr !== 10'd0 || bus.vramInData !== 10'sd250) begin
      errors++;
      $display("FAIL single_new: got we=%b addr=%0d data=%0d expected 1/0/250",
               bus.vramWrEn, bus.vramWriteAddr, bus.vramInData);
    end
    abort_capture();
  endtask

  task automatic test_backpressure_abort();
    int acc = 0;
    int bad = 0;
    int fd = 0;
    int last = -1;
    logic pv = 1'b0;
    runMode = 2'b01;
    trigEnable = 1'b0;
    repeat (2) @(negedge inClock);
    vs_pulse();
    wait_ready("bp");
    bus.sampleData = 10'sd400;
    for (int c = 0; c < 1200 && acc < 500; c++) begin
      @(negedge inClock);
      if (bus.vramWrEn !== pv) bad++;
      if (bus.vramWrEn === 1'b1) begin
        if (bus.vramWriteAddr !== 10'(last + 1) || bus.vramInData !== 10'sd400) bad++;
        last = int'(bus.vramWriteAddr);
      end
      if (bus.frameDone === 1'b1) fd++;
      pv = (c % 2 == 0);
      bus.sampleValid = pv;
      if (pv) acc++;
    end
    @(negedge inClock);
    if (bus.vramWrEn !== pv) bad++;
    if (bus.vramWrEn === 1'b1) last = int'(bus.vramWriteAddr);
    if (bus.frameDone === 1'b1) fd++;
    runMode = 2'b00;
    bus.sampleValid = 1'b1;
    @(negedge inClock);
    if (bus.vramWrEn === 1'b1) last = int'(bus.vramWriteAddr);
    if (bus.frameDone === 1'b1) fd++;
    bus.sampleValid = 1'b0;
    @(negedge inClock);
    if (bus.vramWrEn === 1'b1 || bus.frameDone === 1'b1) fd++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_gaps: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if ((last != 499 && last != 500) || fd != 0 || busy !== 1'b0 || bus.sampleReady !== 1'b0) begin
      errors++;
      $display("FAIL abort: got last=%0d fd=%0d busy=%b rdy=%b expected last 499|500 fd=0 busy=0 rdy=0",
               last, fd, busy, bus.sampleReady);
    end
  endtask

  task automatic test_reset_mid_write();
    runMode = 2'b01;
    trigEnable = 1'b0;
    repeat (2) @(negedge inClock);
    vs_pulse();
    wait_ready("rst");
    bus.sampleValid = 1'b1;
    bus.sampleData  = 10'sd123;
    repeat (5) @(negedge inClock);
    checks++;
    if (bus.vramWrEn !== 1'b1 || bus.vramWriteAddr !== 10'd4 || bus.vramInData !== 10'sd123) begin
      errors++;
      $display("FAIL rst_pre: got we=%b addr=%0d data=%0d expected 1/4/123",
               bus.vramWrEn, bus.vramWriteAddr, bus.vramInData);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (bus.vramWrEn !== 1'b0 || bus.vramWriteAddr !== 10'd0 || bus.vramInData !== 10'sd0 ||
        bus.frameDone !== 1'b0 || busy !== 1'b0 || bus.sampleReady !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got we=%b addr=%0d data=%0d fd=%b busy=%b rdy=%b expected all 0",
               bus.vramWrEn, bus.vramWriteAddr, bus.vramInData, bus.frameDone, busy, bus.sampleReady);
    end
    @(negedge inClock);
    bus.sampleValid = 1'b0;
    runMode = 2'b00;
    resetN = 1'b1;
    repeat (2) @(negedge inClock);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_clamp();
    test_trigger();
    test_timeout();
    test_single();
    test_backpressure_abort();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
